// File: rtl/capture_mem_sender_pkg.sv
// Shared constants for the capture-memory read-out path.
// State encoding (4 bits), bytes-per-word helper and TX handshake timing.
// No logic; imported by capture_mem_sender and capture_mem_byte_shifter.
package capture_mem_sender_pkg;

  localparam int DEFAULT_WORDLEN_BITS = 16;

  function automatic int bytes_per_word(input int wordlen_bits);
    return wordlen_bits / 8;
  endfunction

  localparam int BYTES_PER_WORD = bytes_per_word(DEFAULT_WORDLEN_BITS);

  // The UART only drops tx_ready the cycle after it sees tx_start, so the
  // first cycle of WAIT_TX must not trust tx_ready.
  localparam int TX_IGNORE_CYCLES = 1;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    ACK     = 4'd1,
    RD_WAIT = 4'd2,
    LOAD    = 4'd3,
    SEND    = 4'd4,
    WAIT_TX = 4'd5,
    NEXT    = 4'd6,
    CKSUM   = 4'd7,
    DONE    = 4'd8
  } state_t;

endpackage

// File: rtl/capture_mem_byte_shifter.sv
// Word shift register: parallel load, MSB-first 8-bit left shift, byte counter.
// Latency: load/shift take effect on the next clock; top_byte/last_byte are registered-derived.
// Backpressure: none; the caller decides when to shift.
// Ports: clk, rst_l (async active-low), load, shift, word_in -> top_byte, last_byte.
module capture_mem_byte_shifter
  import capture_mem_sender_pkg::*;
#(
  parameter int WORD_BITS = DEFAULT_WORDLEN_BITS
) (
  input  logic                 clk,
  input  logic                 rst_l,
  input  logic                 load,
  input  logic                 shift,
  input  logic [WORD_BITS-1:0] word_in,
  output logic [7:0]           top_byte,
  output logic                 last_byte
);

  localparam int BYTES    = bytes_per_word(WORD_BITS);
  localparam int IDX_BITS = $clog2(BYTES + 1);

  logic [WORD_BITS-1:0] sreg;
  logic [IDX_BITS-1:0]  byte_idx;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      sreg     <= '0;
      byte_idx <= '0;
    end else if (load) begin
      sreg     <= word_in;
      byte_idx <= '0;
    end else if (shift) begin
      sreg     <= sreg << 8;
      byte_idx <= byte_idx + IDX_BITS'(1);
    end
  end

  assign top_byte  = sreg[WORD_BITS-1 -: 8];
  // High once every byte of the loaded word has been shifted out.
  assign last_byte = (byte_idx == IDX_BITS'(BYTES));

endmodule

// File: rtl/capture_mem_sender.sv
// Streams capture memory (MEM_LAST_ADDR down to 0) byte-wise, MSB first, to the UART TX.
// Latency: ack 1 cycle after sc_run; first tx_start 4 cycles after sc_run if tx_ready is high.
// Backpressure: stalls in SEND/WAIT_TX/CKSUM while tx_ready is low, no timeout.
// Ports: clk, rst_l (async active-low), sc_run/ack_sc_run/sc_done (monitor handshake),
//        mem_port_B_address/mem_port_B_dout (sync-read RAM), tx_ready/tx_start/tx_byte (UART).
// Optional: define CAPTURE_MEM_SENDER_CHECKSUM_EN to append an XOR checksum byte.
module capture_mem_sender
  import capture_mem_sender_pkg::*;
#(
  parameter int MEM_ADDRESS_BITS = 8,
  parameter int MEM_WORDLEN_BITS = DEFAULT_WORDLEN_BITS,
  parameter int MEM_LAST_ADDR    = 255
) (
  input  logic                        clk,
  input  logic                        rst_l,
  input  logic                        sc_run,
  output logic                        ack_sc_run,
  output logic                        sc_done,
  output logic [MEM_ADDRESS_BITS-1:0] mem_port_B_address,
  input  logic [MEM_WORDLEN_BITS-1:0] mem_port_B_dout,
  input  logic                        tx_ready,
  output logic                        tx_start,
  output logic [7:0]                  tx_byte
);

  localparam int IGN_BITS = $clog2(TX_IGNORE_CYCLES + 1);
  localparam logic [MEM_ADDRESS_BITS-1:0] LAST_ADDR = MEM_ADDRESS_BITS'(MEM_LAST_ADDR);

  state_t              state;
  logic [IGN_BITS-1:0] ign_cnt;
  logic [7:0]          top_byte;
  logic                word_sent;
  logic                sh_load;
  logic                sh_shift;

`ifdef CAPTURE_MEM_SENDER_CHECKSUM_EN
  logic [7:0] cksum;
  logic       cksum_sent;
`endif

  assign sh_load  = (state == LOAD);
  assign sh_shift = (state == SEND) && tx_ready;

  capture_mem_byte_shifter #(
    .WORD_BITS (MEM_WORDLEN_BITS)
  ) u_shifter (
    .clk       (clk),
    .rst_l     (rst_l),
    .load      (sh_load),
    .shift     (sh_shift),
    .word_in   (mem_port_B_dout),
    .top_byte  (top_byte),
    .last_byte (word_sent)
  );

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state              <= IDLE;
      ack_sc_run         <= 1'b0;
      sc_done            <= 1'b0;
      tx_start           <= 1'b0;
      tx_byte            <= 8'h00;
      mem_port_B_address <= LAST_ADDR;
      ign_cnt            <= '0;
`ifdef CAPTURE_MEM_SENDER_CHECKSUM_EN
      cksum              <= 8'h00;
      cksum_sent         <= 1'b0;
`endif
    end else begin
      // Strobes default low so each is a single-cycle pulse.
      ack_sc_run <= 1'b0;
      sc_done    <= 1'b0;
      tx_start   <= 1'b0;
      case (state)
        IDLE: begin
          if (sc_run) begin
            state              <= ACK;
            ack_sc_run         <= 1'b1;
            mem_port_B_address <= LAST_ADDR;
`ifdef CAPTURE_MEM_SENDER_CHECKSUM_EN
            cksum              <= 8'h00;
            cksum_sent         <= 1'b0;
`endif
          end
        end
        ACK:     state <= RD_WAIT;
        RD_WAIT: state <= LOAD;   // RAM registers the address this cycle
        LOAD:    state <= SEND;   // shifter captures dout on this edge
        SEND: begin
          if (tx_ready) begin
            tx_start <= 1'b1;
            tx_byte  <= top_byte;
            ign_cnt  <= IGN_BITS'(TX_IGNORE_CYCLES);
`ifdef CAPTURE_MEM_SENDER_CHECKSUM_EN
            cksum    <= cksum ^ top_byte;
`endif
            state    <= WAIT_TX;
          end
        end
        WAIT_TX: begin
          if (ign_cnt != '0) begin
            ign_cnt <= ign_cnt - IGN_BITS'(1);
          end else if (tx_ready) begin
`ifdef CAPTURE_MEM_SENDER_CHECKSUM_EN
            if (cksum_sent) begin
              state   <= DONE;
              sc_done <= 1'b1;
            end else if (word_sent) begin
              state <= NEXT;
            end else begin
              state <= SEND;
            end
`else
            if (word_sent) state <= NEXT;
            else           state <= SEND;
`endif
          end
        end
        NEXT: begin
          // Address 0 terminates, so the decrement can never wrap.
          if (mem_port_B_address == '0) begin
`ifdef CAPTURE_MEM_SENDER_CHECKSUM_EN
            state   <= CKSUM;
`else
            state   <= DONE;
            sc_done <= 1'b1;
`endif
          end else begin
            mem_port_B_address <= mem_port_B_address - MEM_ADDRESS_BITS'(1);
            state              <= RD_WAIT;
          end
        end
`ifdef CAPTURE_MEM_SENDER_CHECKSUM_EN
        CKSUM: begin
          if (tx_ready) begin
            tx_start   <= 1'b1;
            tx_byte    <= cksum;
            ign_cnt    <= IGN_BITS'(TX_IGNORE_CYCLES);
            cksum_sent <= 1'b1;
            state      <= WAIT_TX;
          end
        end
`endif
        DONE:    state <= IDLE;   // sc_done is high during this cycle
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_capture_mem_sender.sv
// Directed bench: small 4-word memory instance plus a 256-word all-ones instance.
// Each comparison is an immediate assertion; a summary line ends the run.
module tb_capture_mem_sender;
  import capture_mem_sender_pkg::*;

`ifdef CAPTURE_MEM_SENDER_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif
  localparam int NB_S = 4 * BYTES_PER_WORD + CK;
  localparam int NB_B = 256 * BYTES_PER_WORD;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_l = 1'b0;

  int total = 0;
  int bad   = 0;

  // ---------------- small instance: MEM_LAST_ADDR = 3 ----------------
  logic        sc_run_s = 1'b0;
  logic        ack_s, done_s, tx_start_s;
  logic        tx_ready_s = 1'b1;
  logic [7:0]  tx_byte_s, addr_s;
  logic [15:0] dout_s;
  logic [15:0] mem_s [0:3] = '{16'h0102, 16'h0304, 16'h0506, 16'h0708};
  logic [7:0]  exp_s [0:8] = '{8'h07, 8'h08, 8'h05, 8'h06, 8'h03, 8'h04, 8'h01, 8'h02, 8'h08};
  bit          hold_s = 1'b0;
  int          busy_s = 0;

  capture_mem_sender #(
    .MEM_ADDRESS_BITS (8),
    .MEM_WORDLEN_BITS (16),
    .MEM_LAST_ADDR    (3)
  ) dut_s (
    .clk                (clk),
    .rst_l              (rst_l),
    .sc_run             (sc_run_s),
    .ack_sc_run         (ack_s),
    .sc_done            (done_s),
    .mem_port_B_address (addr_s),
    .mem_port_B_dout    (dout_s),
    .tx_ready           (tx_ready_s),
    .tx_start           (tx_start_s),
    .tx_byte            (tx_byte_s)
  );

  always @(posedge clk) dout_s <= mem_s[addr_s[1:0]];

  // UART model: ready drops after a start and returns 4 cycles later.
  always @(posedge clk) begin
    if (tx_start_s) begin
      tx_ready_s <= 1'b0;
      busy_s     <= 4;
    end else if (busy_s > 1) begin
      busy_s <= busy_s - 1;
    end else begin
      busy_s     <= 0;
      tx_ready_s <= !hold_s;
    end
  end

  logic [7:0] q_s[$];
  int ack_cnt_s = 0, done_cnt_s = 0;
  always @(negedge clk) begin
    if (tx_start_s === 1'b1) q_s.push_back(tx_byte_s);
    if (ack_s === 1'b1)  ack_cnt_s++;
    if (done_s === 1'b1) done_cnt_s++;
  end

  // ---------------- big instance: MEM_LAST_ADDR = 255, all 0xFFFF ----------------
  logic        sc_run_b = 1'b0;
  logic        ack_b, done_b, tx_start_b;
  logic        tx_ready_b = 1'b1;
  logic [7:0]  tx_byte_b, addr_b;
  logic [15:0] dout_b;
  int          busy_b = 0;

  capture_mem_sender #(
    .MEM_ADDRESS_BITS (8),
    .MEM_WORDLEN_BITS (16),
    .MEM_LAST_ADDR    (255)
  ) dut_b (
    .clk                (clk),
    .rst_l              (rst_l),
    .sc_run             (sc_run_b),
    .ack_sc_run         (ack_b),
    .sc_done            (done_b),
    .mem_port_B_address (addr_b),
    .mem_port_B_dout    (dout_b),
    .tx_ready           (tx_ready_b),
    .tx_start           (tx_start_b),
    .tx_byte            (tx_byte_b)
  );

  always @(posedge clk) dout_b <= 16'hFFFF;

  always @(posedge clk) begin
    if (tx_start_b) begin
      tx_ready_b <= 1'b0;
      busy_b     <= 4;
    end else if (busy_b > 1) begin
      busy_b <= busy_b - 1;
    end else begin
      busy_b     <= 0;
      tx_ready_b <= 1'b1;
    end
  end

  logic [7:0] q_b[$];
  int   ack_cnt_b = 0, done_cnt_b = 0;
  bit   wrap_b = 1'b0;
  logic [7:0] prev_b = 8'hFF;
  always @(negedge clk) begin
    if (tx_start_b === 1'b1) q_b.push_back(tx_byte_b);
    if (ack_b === 1'b1)  ack_cnt_b++;
    if (done_b === 1'b1) done_cnt_b++;
    if (addr_b > prev_b) wrap_b = 1'b1;   // address must only ever count down
    prev_b = addr_b;
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int acks(input bit big);
    return big ? ack_cnt_b : ack_cnt_s;
  endfunction

  function automatic int dones(input bit big);
    return big ? done_cnt_b : done_cnt_s;
  endfunction

  // Raise sc_run, wait for the ack, keep it high 'hold' more cycles, drop it.
  task automatic start_run(input bit big, input int hold, input string tag);
    int a0 = acks(big);
    int n  = 0;
    if (big) sc_run_b = 1'b1; else sc_run_s = 1'b1;
    while (acks(big) == a0 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check({tag, "_ack_seen"}, 32'(acks(big) - a0), 32'd1);
    repeat (hold) @(negedge clk);
    if (big) sc_run_b = 1'b0; else sc_run_s = 1'b0;
  endtask

  task automatic wait_done(input bit big, input int d0, input int budget, input string tag);
    int n = 0;
    while (dones(big) == d0 && n < budget) begin
      @(negedge clk); #1; n++;
    end
    check({tag, "_done_seen"}, 32'(dones(big) - d0), 32'd1);
  endtask

  task automatic check_stream(input string tag);
    check({tag, "_nbytes"}, 32'(q_s.size()), 32'(NB_S));
    for (int i = 0; i < NB_S; i++)
      if (i < q_s.size())
        check($sformatf("%s_byte%0d", tag, i), 32'(q_s[i]), 32'(exp_s[i]));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int a0, d0, n, nff;

    repeat (3) @(negedge clk);
    #1;
    check("rst_ack",      32'(ack_s),      32'd0);
    check("rst_done",     32'(done_s),     32'd0);
    check("rst_tx_start", 32'(tx_start_s), 32'd0);
    check("rst_tx_byte",  32'(tx_byte_s),  32'd0);
    check("rst_addr_s",   32'(addr_s),     32'd3);
    check("rst_addr_b",   32'(addr_b),     32'd255);
    @(negedge clk);
    rst_l = 1'b1;
    repeat (2) @(negedge clk);

    // T1: basic read-out
    q_s.delete(); a0 = ack_cnt_s; d0 = done_cnt_s;
    start_run(1'b0, 0, "t1");
    wait_done(1'b0, d0, 2000, "t1");
    repeat (10) @(negedge clk);
    #1;
    check("t1_ack_count",  32'(ack_cnt_s - a0),  32'd1);
    check("t1_done_count", 32'(done_cnt_s - d0), 32'd1);
    check_stream("t1");

    // T2: UART not ready for 50 cycles before the first byte
    q_s.delete(); d0 = done_cnt_s;
    hold_s = 1'b1;
    repeat (8) @(negedge clk);
    start_run(1'b0, 0, "t2");
    repeat (50) @(negedge clk);
    #1;
    check("t2_no_start_while_busy", 32'(q_s.size()), 32'd0);
    hold_s = 1'b0;
    wait_done(1'b0, d0, 2000, "t2");
    repeat (10) @(negedge clk);
    #1;
    check_stream("t2");

    // T3: sc_run held 10 cycles past the ack
    q_s.delete(); a0 = ack_cnt_s; d0 = done_cnt_s;
    start_run(1'b0, 10, "t3");
    wait_done(1'b0, d0, 2000, "t3");
    repeat (30) @(negedge clk);
    #1;
    check("t3_ack_count",  32'(ack_cnt_s - a0),  32'd1);
    check("t3_done_count", 32'(done_cnt_s - d0), 32'd1);
    check_stream("t3");

    // T4: reset after the 3rd byte, then a clean restart
    q_s.delete();
    start_run(1'b0, 0, "t4a");
    n = 0;
    while (q_s.size() < 3 && n < 500) begin
      @(negedge clk); #1; n++;
    end
    check("t4_three_bytes", 32'(q_s.size()), 32'd3);
    rst_l = 1'b0;
    #1;
    check("t4_abort_tx_start", 32'(tx_start_s), 32'd0);
    check("t4_abort_addr",     32'(addr_s),     32'd3);
    check("t4_abort_tx_byte",  32'(tx_byte_s),  32'd0);
    repeat (2) @(negedge clk);
    rst_l = 1'b1;
    repeat (2) @(negedge clk);
    q_s.delete(); d0 = done_cnt_s;
    start_run(1'b0, 0, "t4b");
    wait_done(1'b0, d0, 2000, "t4");
    repeat (10) @(negedge clk);
    #1;
    check_stream("t4");

    // T5: 256 words of 0xFFFF
    q_b.delete(); a0 = ack_cnt_b; d0 = done_cnt_b;
    start_run(1'b1, 0, "t5");
    wait_done(1'b1, d0, 20000, "t5");
    repeat (10) @(negedge clk);
    #1;
    check("t5_nbytes", 32'(q_b.size()), 32'(NB_B + CK));
    nff = 0;
    for (int i = 0; i < NB_B && i < q_b.size(); i++)
      if (q_b[i] !== 8'hFF) nff++;
    check("t5_all_ff",     32'(nff),               32'd0);
    check("t5_no_wrap",    32'(wrap_b),            32'd0);
    check("t5_end_addr",   32'(addr_b),            32'd0);
    check("t5_done_count", 32'(done_cnt_b - d0),   32'd1);
    check("t5_ack_count",  32'(ack_cnt_b - a0),    32'd1);
    if (CK == 1 && q_b.size() > NB_B)
      check("t5_cksum", 32'(q_b[NB_B]), 32'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/capture_mem_sender.md
Name: capture_mem_sender

Overview:
- Read-out counterpart of the capture monitor: on `sc_run`, walks the capture memory through read port B and streams every word, byte by byte, to the UART byte transmitter.
- Signals completion back on `sc_done`.
- Sits between the dual-port capture RAM (port B, synchronous read) and the UART TX.

Parameters:
- MEM_ADDRESS_BITS, 8, capture memory address width.
- MEM_WORDLEN_BITS, 16, memory word width; must be a multiple of 8.
- MEM_LAST_ADDR, 255, highest memory address; read-out covers MEM_LAST_ADDR down to 0.

Ports:
- clk  in  1  system clock.
- rst_l  in  1  reset.
- sc_run  in  1  level request from the monitor; held until acknowledged.
- ack_sc_run  out  1  one-cycle acknowledge of sc_run.
- sc_done  out  1  one-cycle pulse when read-out is complete.
- mem_port_B_address  out  MEM_ADDRESS_BITS  read address.
- mem_port_B_dout  in  MEM_WORDLEN_BITS  read data, valid 1 cycle after address.
- tx_ready  in  1  UART TX idle; must drop the cycle after tx_start.
- tx_start  out  1  one-cycle byte-send strobe.
- tx_byte  out  8  byte to send; stable while tx_start is high.

Interface fixed: one clock `clk`; reset `rst_l` is asynchronous, active-low.

Behaviour:
- Reset values: ack_sc_run=0, sc_done=0, tx_start=0, tx_byte=0, mem_port_B_address=MEM_LAST_ADDR, state IDLE, internal counters 0.
- Reset asserted mid-operation aborts immediately to these values. No partial word is resumed.
- All outputs are registered.
- BYTES = MEM_WORDLEN_BITS/8.
- States: IDLE, ACK, RD_WAIT, LOAD, SEND, WAIT_TX, NEXT, [CKSUM], DONE.
- IDLE: on sc_run=1 -> ACK; address register = MEM_LAST_ADDR; byte index = 0.
- ACK: ack_sc_run=1 for exactly this cycle -> RD_WAIT. The monitor drops sc_run the following cycle. sc_run is ignored outside IDLE.
- RD_WAIT: one cycle for RAM latency -> LOAD.
- LOAD: capture mem_port_B_dout into word shift register -> SEND.
- SEND: wait for tx_ready=1.
  - Then drive tx_byte = upper byte of the shift register (MSB-first), pulse tx_start one cycle -> WAIT_TX.
  - Shift register shifts left 8; byte index +1.
- WAIT_TX: tx_ready is ignored in the first cycle after entry, then wait for tx_ready=1.
  - If byte index < BYTES -> SEND.
  - Otherwise -> NEXT.
- NEXT:
  - If address == 0 -> CKSUM (if compiled in) else DONE.
  - Otherwise address -1, byte index 0 -> RD_WAIT.
- DONE: sc_done=1 for one cycle -> IDLE.
- Total bytes sent = (MEM_LAST_ADDR+1)*BYTES (+1 with checksum).
- Per-byte cost is ≥3 cycles + UART time. sc_run is therefore guaranteed low before sc_done, as the monitor requires.
- Address arithmetic is MEM_ADDRESS_BITS wide; the decrement never wraps because address 0 terminates.
- If tx_ready is already low in SEND, the block stalls indefinitely; there is no timeout.

Optional Feature:
- Macro: CAPTURE_MEM_SENDER_CHECKSUM_EN.
- Defined:
  - 8-bit register cksum, cleared on IDLE->ACK, XOR-accumulates every byte at its tx_start.
  - State CKSUM waits for tx_ready and sends cksum as the final byte with the same tx_start/WAIT_TX rules, then -> DONE.
- Undefined: state and register absent; NEXT at address 0 goes directly to DONE.

Decomposition:
- Shared package (alongside the existing internal common include):
  - state encoding constants, 4 bits;
  - BYTES_PER_WORD derived constant;
  - TX handshake timing constant (1-cycle ignore).
- Sub-module capture_mem_byte_shifter: parallel load, 8-bit left shift, byte index counter, last-byte flag.
- The FSM stays in the top module.

Test Plan:
- Reset, MEM_LAST_ADDR=3, mem={0:0x0102,1:0x0304,2:0x0506,3:0x0708}, sc_run=1, UART model ready 4 cycles after each start -> ack_sc_run pulses once; bytes 07 08 05 06 03 04 01 02; then a single sc_done pulse; tx_start count=8.
- Same memory, tx_ready held low 50 cycles before the first byte -> no tx_start until tx_ready=1, then identical byte stream.
- sc_run held high 10 cycles after ack -> only one ack_sc_run pulse and one read-out; returns to IDLE.
- rst_l asserted after 3rd byte, released, sc_run reasserted -> restarts from address 3, first byte 07, full 8-byte stream.
- CAPTURE_MEM_SENDER_CHECKSUM_EN defined, same memory -> 9th byte = 0x08 (XOR of 01..08), then sc_done.
- Memory word 0xFFFF at every address, MEM_LAST_ADDR=255 -> exactly 512 bytes of 0xFF; address never wraps; sc_done once.
